inst_fetch_q: RTL and testbench

//  Instruction fetch queue between the PC generator and decode. Turns each PC

---
 rtl/inst_fetch_q_if.sv | 37 +++
 rtl/inst_fetch_q.sv | 106 ++++++++++
 tb/tb_inst_fetch_q.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_q_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_q_if : PC-stage / instruction-bus / decode signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

interface inst_fetch_q_if;
   logic [31:0] pc_i;
   logic        pc_valid_i;
   logic        pc_ready_o;
   logic        flush_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_gnt_i;
   logic        ibus_rvalid_i;
   logic [31:0] ibus_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_ready_i;

   // master: the fetch queue itself; slave: PC stage, bus and decode around it
   modport master (
      input  pc_i, pc_valid_i, flush_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, inst_ready_i,
      output pc_ready_o, ibus_req_o, ibus_addr_o, inst_valid_o, inst_o, inst_addr_o
   );
   modport slave (
      output pc_i, pc_valid_i, flush_i, ibus_gnt_i, ibus_rvalid_i, ibus_rdata_i, inst_ready_i,
      input  pc_ready_o, ibus_req_o, ibus_addr_o, inst_valid_o, inst_o, inst_addr_o
   );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_q.sv
// ---------------------------------------------------------------------------
// inst_fetch_q : in-order instruction fetch queue with flush and drop counting
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module inst_fetch_q #(
   parameter int DEPTH = 2
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   inst_fetch_q_if.master  bus
);
   localparam int c_PW = $clog2(DEPTH);
   localparam int c_CW = c_PW + 1;

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_PENDING = 2'd1,
      S_READY   = 2'd2
   } slot_t;

   slot_t           r_st   [DEPTH];
   logic [31:0]     r_pc   [DEPTH];
   logic [31:0]     r_data [DEPTH];
   logic [c_PW-1:0] r_wr_ptr;
   logic [c_PW-1:0] r_rd_ptr;
   logic [c_PW-1:0] r_rsp_ptr;
   logic [c_CW-1:0] r_drop_cnt;

   logic            w_req;
   logic            w_grant;
   logic            w_valid;
   logic            w_consume;
   logic            w_fill;
   logic [c_CW-1:0] w_npend;
   logic [c_CW-1:0] w_drop_sum;
   logic [c_CW-1:0] w_drop_flush;

   // Pending slots are contiguous from r_rsp_ptr, so it always names the oldest one.
   assign w_req     = rst_n & bus.pc_valid_i & ~bus.flush_i &
                      (r_st[r_wr_ptr] == S_EMPTY) & (r_drop_cnt == '0);
   assign w_grant   = w_req & bus.ibus_gnt_i;
   assign w_valid   = rst_n & (r_st[r_rd_ptr] == S_READY) & ~bus.flush_i;
   assign w_consume = w_valid & bus.inst_ready_i;
   assign w_fill    = bus.ibus_rvalid_i & (r_drop_cnt == '0) & (r_st[r_rsp_ptr] == S_PENDING);

   always_comb begin
      w_npend = '0;
      for (int i = 0; i < DEPTH; i++)
         w_npend = w_npend + c_CW'(r_st[i] == S_PENDING);
   end

   assign w_drop_sum   = r_drop_cnt + w_npend;
   assign w_drop_flush = (bus.ibus_rvalid_i && (w_drop_sum != '0)) ? w_drop_sum - c_CW'(1)
                                                                   : w_drop_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_st[i]   <= S_EMPTY;
            r_pc[i]   <= '0;
            r_data[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rsp_ptr  <= '0;
         r_drop_cnt <= '0;
      end else if (bus.flush_i) begin
         for (int i = 0; i < DEPTH; i++)
            r_st[i] <= S_EMPTY;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rsp_ptr  <= '0;
         r_drop_cnt <= w_drop_flush;
      end else begin
         if ((r_drop_cnt != '0) && bus.ibus_rvalid_i)
            r_drop_cnt <= r_drop_cnt - c_CW'(1);
         // fill, consume and grant always touch three different slots
         if (w_fill) begin
            r_st[r_rsp_ptr]   <= S_READY;
            r_data[r_rsp_ptr] <= bus.ibus_rdata_i;
            r_rsp_ptr         <= r_rsp_ptr + c_PW'(1);
         end
         if (w_consume) begin
            r_st[r_rd_ptr] <= S_EMPTY;
            r_rd_ptr       <= r_rd_ptr + c_PW'(1);
         end
         if (w_grant) begin
            r_st[r_wr_ptr] <= S_PENDING;
            r_pc[r_wr_ptr] <= bus.pc_i;
            r_wr_ptr       <= r_wr_ptr + c_PW'(1);
         end
      end
   end

   assign bus.ibus_req_o   = w_req;
   assign bus.ibus_addr_o  = bus.pc_i;
   assign bus.pc_ready_o   = w_grant;
   assign bus.inst_valid_o = w_valid;
   assign bus.inst_o       = w_valid ? r_data[r_rd_ptr] : `INST_NOP;
   assign bus.inst_addr_o  = w_valid ? r_pc[r_rd_ptr]   : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_q.sv
// Testbench for inst_fetch_q: queue-level reference model checked every cycle,
// plus directed scenarios with hand-derived expectations.
`default_nettype none

module tb_inst_fetch_q;
   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   inst_fetch_q_if bif ();

   inst_fetch_q #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int lat   = 1;
   bit m_gnt = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hA5C3_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of fetches plus a count of responses to discard.
   typedef struct { logic [31:0] pc; logic [31:0] data; bit rdy; } ent_t;
   typedef struct { logic [31:0] a; int c; } out_t;
   ent_t mq[$];
   out_t bq[$];
   int   mdrop = 0;

   logic [31:0] cons_a[$];
   int          cons_c[$];
   logic [31:0] cons_d[$];
   logic [31:0] gl_a[$];
   int          gl_c[$];

   always @(negedge clk) begin : cmp
      logic        e_req, e_gnt, e_val;
      logic [31:0] e_inst, e_addr;
      int          np;
      e_req  = rst_n && bif.pc_valid_i && !bif.flush_i && (mq.size() < DEPTH) && (mdrop == 0);
      e_gnt  = e_req && bif.ibus_gnt_i;
      e_val  = rst_n && (mq.size() > 0) && mq[0].rdy && !bif.flush_i;
      e_inst = e_val ? mq[0].data : NOP;
      e_addr = e_val ? mq[0].pc   : 32'h0;
      chk("ibus_req",   bif.ibus_req_o,   e_req);
      chk("pc_ready",   bif.pc_ready_o,   e_gnt);
      chk("ibus_addr",  bif.ibus_addr_o,  bif.pc_i);
      chk("inst_valid", bif.inst_valid_o, e_val);
      chk("inst",       bif.inst_o,       e_inst);
      chk("inst_addr",  bif.inst_addr_o,  e_addr);

      if (bif.inst_valid_o && bif.inst_ready_i) begin
         cons_a.push_back(bif.inst_addr_o);
         cons_d.push_back(bif.inst_o);
         cons_c.push_back(cyc);
      end
      if (bif.ibus_req_o && bif.ibus_gnt_i) begin
         gl_a.push_back(bif.ibus_addr_o);
         gl_c.push_back(cyc);
      end
      m_gnt = e_gnt;

      if (!rst_n) begin
         mq.delete();
         bq.delete();
         mdrop = 0;
      end else if (bif.flush_i) begin
         np = 0;
         foreach (mq[i]) if (!mq[i].rdy) np++;
         mdrop = mdrop + np - (bif.ibus_rvalid_i ? 1 : 0);
         if (mdrop < 0) mdrop = 0;
         mq.delete();
      end else begin
         if (bif.ibus_rvalid_i) begin
            if (mdrop > 0) mdrop--;
            else begin
               for (int i = 0; i < mq.size(); i++) begin
                  if (!mq[i].rdy) begin
                     mq[i].rdy  = 1'b1;
                     mq[i].data = bif.ibus_rdata_i;
                     break;
                  end
               end
            end
         end
         if (e_val && bif.inst_ready_i) void'(mq.pop_front());
         if (e_gnt) begin
            mq.push_back('{pc: bif.pc_i, data: 32'h0, rdy: 1'b0});
            bq.push_back('{a: bif.pc_i, c: cyc});
         end
      end
   end

   // Bus responder: in-order read data, lat cycles after grant.
   initial begin
      bif.ibus_rvalid_i = 1'b0;
      bif.ibus_rdata_i  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && (bq.size() > 0) && (bq[0].c + lat <= cyc)) begin
            bif.ibus_rvalid_i = 1'b1;
            bif.ibus_rdata_i  = memf(bq[0].a);
            void'(bq.pop_front());
         end else begin
            bif.ibus_rvalid_i = 1'b0;
            bif.ibus_rdata_i  = 32'hDEAD_BEEF;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_logs();
      cons_a.delete(); cons_c.delete(); cons_d.delete();
      gl_a.delete();   gl_c.delete();
   endtask

   task automatic issue(input logic [31:0] a, output int waited);
      bif.pc_i       = a;
      bif.pc_valid_i = 1'b1;
      waited         = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (m_gnt) break;
         waited++;
      end
      if (waited >= 60) begin
         n_cmp++;
         n_bad++;
         $display("FAIL issue_timeout: pc %h never granted", a);
      end
      bif.pc_valid_i = 1'b0;
   endtask

   initial begin : wdog
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int w;
      rst_n             = 1'b0;
      bif.pc_i          = 32'h0;
      bif.pc_valid_i    = 1'b1;
      bif.flush_i       = 1'b0;
      bif.ibus_gnt_i    = 1'b1;
      bif.inst_ready_i  = 1'b0;
      step();
      chk("rst_req",   bif.ibus_req_o,   1'b0);
      chk("rst_inst",  bif.inst_o,       NOP);
      chk("rst_valid", bif.inst_valid_o, 1'b0);
      bif.pc_valid_i = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // 1: stream 0,4,8,C with 1-cycle response latency
      lat = 1; bif.inst_ready_i = 1'b1; clr_logs();
      issue(32'h0, w); issue(32'h4, w); issue(32'h8, w); issue(32'hC, w);
      repeat (6) step();
      chk("t1_count", cons_a.size(), 4);
      if (cons_a.size() == 4 && gl_c.size() > 0) begin
         chk("t1_a0", cons_a[0], 32'h0);
         chk("t1_a1", cons_a[1], 32'h4);
         chk("t1_a2", cons_a[2], 32'h8);
         chk("t1_a3", cons_a[3], 32'hC);
         chk("t1_d3", cons_d[3], 32'hA5C3_000C);
         chk("t1_fill", cons_c[0] - gl_c[0], 2);
         chk("t1_gap1", cons_c[1] - cons_c[0], 1);
         chk("t1_gap3", cons_c[3] - cons_c[0], 4);
      end

      // 2: full queue with decode stalled
      bif.inst_ready_i = 1'b0; clr_logs();
      issue(32'h0, w); issue(32'h4, w);
      bif.pc_i = 32'h8; bif.pc_valid_i = 1'b1;
      step(); step();
      chk("t2_full_req",   bif.ibus_req_o, 1'b0);
      chk("t2_full_ready", bif.pc_ready_o, 1'b0);
      bif.inst_ready_i = 1'b1;
      issue(32'h8, w);
      chk("t2_resume_wait", w, 1);
      repeat (5) step();
      chk("t2_ngrant", gl_a.size(), 3);
      chk("t2_ncons",  cons_a.size(), 3);
      if (cons_a.size() == 3 && gl_a.size() == 3) begin
         chk("t2_g2", gl_a[2], 32'h8);
         chk("t2_c1", cons_a[1], 32'h4);
         chk("t2_c2", cons_a[2], 32'h8);
      end

      // 3: flush with two fetches in flight, jump to 0x100
      lat = 3; clr_logs();
      issue(32'h4, w); issue(32'h8, w);
      bif.flush_i = 1'b1;
      step();
      bif.flush_i = 1'b0;
      issue(32'h100, w);
      chk("t3_wait", w, 2);
      repeat (6) step();
      chk("t3_ncons", cons_a.size(), 1);
      if (cons_a.size() == 1) chk("t3_first", cons_a[0], 32'h100);
      if (gl_c.size() == 3) chk("t3_gdelay", gl_c[2] - gl_c[1], 4);

      // 4: flush coincident with rvalid and ready (one READY, one PENDING)
      lat = 1; bif.inst_ready_i = 1'b0; clr_logs();
      issue(32'h200, w); issue(32'h204, w);
      bif.flush_i = 1'b1; bif.inst_ready_i = 1'b1;
      step();
      bif.flush_i = 1'b0;
      chk("t4_valid_after", bif.inst_valid_o, 1'b0);
      issue(32'h300, w);
      chk("t4_wait", w, 0);
      repeat (4) step();
      chk("t4_ncons", cons_a.size(), 1);
      if (cons_a.size() == 1) chk("t4_first", cons_a[0], 32'h300);

      // 4b: flush with two PENDING while one of them returns
      lat = 2; clr_logs();
      issue(32'h4, w); issue(32'h8, w);
      bif.flush_i = 1'b1;
      step();
      bif.flush_i = 1'b0;
      issue(32'h180, w);
      chk("t4b_wait", w, 1);
      repeat (5) step();
      chk("t4b_ncons", cons_a.size(), 1);
      if (cons_a.size() == 1) chk("t4b_first", cons_a[0], 32'h180);

      // 5: bus stall for five cycles
      lat = 1; clr_logs();
      bif.ibus_gnt_i = 1'b0; bif.pc_i = 32'h400; bif.pc_valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t5_stall_ready", bif.pc_ready_o, 1'b0);
         chk("t5_stall_req",   bif.ibus_req_o, 1'b1);
      end
      bif.ibus_gnt_i = 1'b1;
      issue(32'h400, w);
      chk("t5_wait", w, 0);
      repeat (4) step();
      chk("t5_ngrant", gl_a.size(), 1);
      if (cons_a.size() == 1) chk("t5_first", cons_a[0], 32'h400);
      else chk("t5_ncons", cons_a.size(), 1);

      // 6: asynchronous reset in the middle of a fetch
      lat = 3;
      issue(32'h500, w);
      bif.pc_i = 32'h504; bif.pc_valid_i = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_req",   bif.ibus_req_o,   1'b0);
      chk("t6_ready", bif.pc_ready_o,   1'b0);
      chk("t6_valid", bif.inst_valid_o, 1'b0);
      chk("t6_inst",  bif.inst_o,       NOP);
      chk("t6_addr",  bif.inst_addr_o,  32'h0);
      clr_logs();
      step(); step();
      bif.pc_i = 32'h600;
      #2;
      rst_n = 1'b1;
      issue(32'h600, w);
      repeat (6) step();
      chk("t6_ncons", cons_a.size(), 1);
      if (cons_a.size() == 1) chk("t6_first", cons_a[0], 32'h600);
      if (gl_a.size() > 0) chk("t6_grant0", gl_a[0], 32'h600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
